// File: rtl/dot_product_accum.sv
// -----------------------------------------------------------------------------
// dot_product_accum
//
// Sequential multiply-accumulate stage. A job is opened with a start pulse
// that carries the beat count (len). The block then accepts that many unsigned
// 8x8 operand pairs over a valid/ready stream. It sums their 16-bit products
// into an ACC_W-bit accumulator and presents the result on a held valid/ready
// output.
//
// Optional feature (compile-time macro):
//   DOT_PRODUCT_SATURATE_EN
//     defined   : a carry out of the accumulator clamps it to 2^ACC_W-1 for
//                 the rest of the job.
//     undefined : the accumulator wraps modulo 2^ACC_W.
//   In both builds, overflow is sticky and set by any carry out.
//
// Parameters:
//   ACC_W      accumulator / result width, legal range 16..32
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      job start pulse, sampled only in IDLE
//   len        beats in the job, sampled with start (0 = empty job)
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (high only in ACCUM)
//   in_x/in_y  unsigned 8-bit operands
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   out_sum    accumulated sum, held after the handshake until the next start
//   overflow   sticky carry-out flag for the current job
//   busy       high in ACCUM or DONE
// -----------------------------------------------------------------------------

// 8x8 unsigned combinational multiplier feeding the accumulator.
module multipliern (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] z
);
  assign z = x * y;
endmodule

module dot_product_accum #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]       remaining, remaining_nxt;
  logic             ovf, ovf_nxt;

  logic [15:0]      product;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             beat;

  multipliern u_mul (
    .x (in_x),
    .y (in_y),
    .z (product)
  );

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign sum_ext = {1'b0, acc} + {{(ACC_W-15){1'b0}}, product};
  assign carry   = sum_ext[ACC_W];

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign beat      = in_valid & in_ready;

  // The accumulator is the result register. It is cleared only by start or by
  // reset, so its value persists after the output handshake.
  assign out_sum  = acc;
  assign overflow = ovf;

  always_comb begin
    // NOTE: every signal assigned here receives a default first. Any path that
    // leaves a variable unassigned would otherwise infer a latch.
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf;

    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (len == 8'd0) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = len;
            state_nxt     = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (beat) begin
          remaining_nxt = remaining - 8'd1;
          if (carry) ovf_nxt = 1'b1;
`ifdef DOT_PRODUCT_SATURATE_EN
          // Once clamped, every further non-zero product carries again, so the
          // accumulator stays at full scale without a separate flag.
          acc_nxt = carry ? '1 : sum_ext[ACC_W-1:0];
`else
          acc_nxt = sum_ext[ACC_W-1:0];
`endif
          if (remaining == 8'd1) state_nxt = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset clears the whole datapath, not only the control state.
  // out_sum reads the accumulator directly, so a reset must present 0 there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values held before the edge, regardless of statement order.
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule
